// File: rtl/pll_phase_ctrl.sv
// Phase-shift and reset sequencer for the GTP_PLL_E3 dynamic phase port group.
// Runs from a free-running reference clock; pll_lock is treated as asynchronous.
module pll_phase_ctrl #(
  parameter int unsigned STEP_LOW_CYC = 4,
  parameter int unsigned STEP_GAP_CYC = 8,
  parameter int unsigned RST_CYC      = 16,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_sel,
  input  logic       req_dir,
  input  logic [7:0] req_steps,
  output logic       busy,
  output logic       done,
  output logic       locked,
  output logic       lock_lost,
  output logic       err_timeout,
  output logic       pll_rst,
  output logic [2:0] phase_sel,
  output logic       phase_dir,
  output logic       phase_step_n,
  output logic       load_phase
);

  localparam logic [15:0] RstLast  = 16'(RST_CYC - 1);
  localparam logic [15:0] WaitLast = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] LowLast  = 16'(STEP_LOW_CYC - 1);
  localparam logic [15:0] GapLast  = 16'(STEP_GAP_CYC - 1);

  typedef enum logic [2:0] {
    StRst, StWaitLock, StIdle, StSetup, StStepLo, StStepHi, StLoad, StDone
  } state_e;

  state_e                 state_q;
  logic [15:0]            cnt_q;
  logic [7:0]             steps_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic                   operating;

  logic       req_ready_q, busy_q, done_q, locked_q, lock_lost_q, err_timeout_q;
  logic       pll_rst_q, phase_dir_q, phase_step_n_q, load_phase_q;
  logic [2:0] phase_sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
    end
  end

  assign lock_s    = sync_q[SYNC_STAGES-1];
  assign operating = (state_q != StRst) && (state_q != StWaitLock);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StRst;
      cnt_q          <= '0;
      steps_q        <= '0;
      req_ready_q    <= 1'b0;
      busy_q         <= 1'b1;
      done_q         <= 1'b0;
      locked_q       <= 1'b0;
      lock_lost_q    <= 1'b0;
      err_timeout_q  <= 1'b0;
      pll_rst_q      <= 1'b1;
      phase_sel_q    <= '0;
      phase_dir_q    <= 1'b0;
      phase_step_n_q <= 1'b1;
      load_phase_q   <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      lock_lost_q  <= 1'b0;
      load_phase_q <= 1'b0;
      cnt_q        <= cnt_q + 16'd1;
      if (operating && !lock_s) begin
        // Lock loss wins over any handshake or step transition this cycle.
        state_q        <= StRst;
        cnt_q          <= '0;
        lock_lost_q    <= 1'b1;
        locked_q       <= 1'b0;
        phase_step_n_q <= 1'b1;
        pll_rst_q      <= 1'b1;
        req_ready_q    <= 1'b0;
        busy_q         <= 1'b1;
      end else begin
        unique case (state_q)
          StRst: begin
            if (cnt_q == RstLast) begin
              state_q   <= StWaitLock;
              cnt_q     <= '0;
              pll_rst_q <= 1'b0;
            end
          end
          StWaitLock: begin
            if (lock_s) begin
              state_q       <= StIdle;
              cnt_q         <= '0;
              locked_q      <= 1'b1;
              err_timeout_q <= 1'b0;
              req_ready_q   <= 1'b1;
              busy_q        <= 1'b0;
            end else if (cnt_q == WaitLast) begin
              state_q       <= StRst;
              cnt_q         <= '0;
              err_timeout_q <= 1'b1;
              pll_rst_q     <= 1'b1;
            end
          end
          StIdle: begin
            cnt_q <= '0;
            if (req_valid) begin
              // The capture registers drive the PLL directly, so sel/dir are
              // already stable during SETUP and hold after the request ends.
              state_q     <= StSetup;
              phase_sel_q <= req_sel;
              phase_dir_q <= req_dir;
              steps_q     <= req_steps;
              req_ready_q <= 1'b0;
              busy_q      <= 1'b1;
            end
          end
          StSetup: begin
            cnt_q <= '0;
            if (steps_q == 8'd0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q        <= StStepLo;
              phase_step_n_q <= 1'b0;
            end
          end
          StStepLo: begin
            if (cnt_q == LowLast) begin
              state_q        <= StStepHi;
              cnt_q          <= '0;
              phase_step_n_q <= 1'b1;
              steps_q        <= steps_q - 8'd1;
            end
          end
          StStepHi: begin
            if (cnt_q == GapLast) begin
              cnt_q <= '0;
              if (steps_q != 8'd0) begin
                state_q        <= StStepLo;
                phase_step_n_q <= 1'b0;
              end else begin
                state_q      <= StLoad;
                load_phase_q <= 1'b1;
              end
            end
          end
          StLoad: begin
            state_q <= StDone;
            cnt_q   <= '0;
            done_q  <= 1'b1;
          end
          StDone: begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
          default: begin
            state_q <= StRst;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign req_ready    = req_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign locked       = locked_q;
  assign lock_lost    = lock_lost_q;
  assign err_timeout  = err_timeout_q;
  assign pll_rst      = pll_rst_q;
  assign phase_sel    = phase_sel_q;
  assign phase_dir    = phase_dir_q;
  assign phase_step_n = phase_step_n_q;
  assign load_phase   = load_phase_q;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Bench for pll_phase_ctrl: directed and randomized phase requests checked cycle by
// cycle against timing computed from the request length, lock drops and timeouts.
module tb_pll_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_lock;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_sel;
  logic       req_dir;
  logic [7:0] req_steps;
  logic       busy, done, locked, lock_lost, err_timeout, pll_rst;
  logic [2:0] phase_sel;
  logic       phase_dir, phase_step_n, load_phase;

  int n_vec = 0;
  int n_err = 0;
  logic [2:0] last_sel = 3'd0;
  logic       last_dir = 1'b0;

  pll_phase_ctrl #(
    .STEP_LOW_CYC(4),
    .STEP_GAP_CYC(8),
    .RST_CYC     (16),
    .LOCK_TIMEOUT(100),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_lock    (pll_lock),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_sel     (req_sel),
    .req_dir     (req_dir),
    .req_steps   (req_steps),
    .busy        (busy),
    .done        (done),
    .locked      (locked),
    .lock_lost   (lock_lost),
    .err_timeout (err_timeout),
    .pll_rst     (pll_rst),
    .phase_sel   (phase_sel),
    .phase_dir   (phase_dir),
    .phase_step_n(phase_step_n),
    .load_phase  (load_phase)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packed order: ready busy done locked lock_lost err_timeout pll_rst step_n load
  task automatic chk_outs(input string tag, input bit rdy, input bit bsy, input bit dn,
                          input bit lkd, input bit lost, input bit err, input bit prst,
                          input bit stpn, input bit ld);
    logic [31:0] obs;
    logic [31:0] exp;
    obs = 32'({req_ready, busy, done, locked, lock_lost, err_timeout, pll_rst,
               phase_step_n, load_phase});
    exp = 32'({rdy, bsy, dn, lkd, lost, err, prst, stpn, ld});
    chk(tag, obs, exp);
  endtask

  // Assert reset mid-cycle, release it, and raise pll_lock lock_at cycles later.
  task automatic reset_seq(input int lock_at);
    bit up;
    rst_n     = 1'b0;
    pll_lock  = 1'b0;
    req_valid = 1'b0;
    #2;
    chk_outs("reset_outs", 0, 1, 0, 0, 0, 0, 1, 1, 0);
    chk("reset_phase", 32'({phase_dir, phase_sel}), 32'd0);
    last_sel = 3'd0;
    last_dir = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i <= lock_at + 4; i++) begin
      if (i > 0) tick();
      up = (i >= lock_at + 3);
      chk_outs("rst_seq", up, !up, 0, up, 0, 0, i < 16, 1, 0);
      if (i == lock_at) pll_lock = 1'b1;
    end
  endtask

  // One request issued at obs 0 (must be IDLE). drop_k >= 0 drops pll_lock at that
  // obs; hold keeps req_valid high with scrambled fields while the request runs.
  task automatic do_req(input logic [2:0] sel, input logic dir, input int steps,
                        input bit hold, input int drop_k);
    int  done_k, end_k, react, last;
    bit  stpn, ld, dn, rdy, bsy, lkd, lost, prst;
    done_k = (steps > 0) ? 3 + 12 * steps : 2;
    end_k  = done_k + 1;
    react  = (drop_k >= 0) ? drop_k + 3 : 32'h3fff_ffff;
    last   = (drop_k >= 0) ? react + 19 : end_k;
    chk_outs("req_idle", 1, 0, 0, 1, 0, 0, 0, 1, 0);
    req_valid = 1'b1;
    req_sel   = sel;
    req_dir   = dir;
    req_steps = 8'(steps);
    for (int k = 1; k <= last; k++) begin
      tick();
      if (k < react) begin
        stpn = !(steps > 0 && k >= 2 && k < 2 + 12 * steps && ((k - 2) % 12) < 4);
        ld   = (steps > 0) && (k == 2 + 12 * steps);
        dn   = (k == done_k);
        rdy  = (k == end_k);
        bsy  = (k < end_k);
        lkd  = 1'b1;
        lost = 1'b0;
        prst = 1'b0;
      end else begin
        stpn = 1'b1;
        ld   = 1'b0;
        dn   = 1'b0;
        rdy  = 1'b0;
        bsy  = 1'b1;
        lkd  = 1'b0;
        lost = (k == react);
        prst = (k < react + 16);
      end
      chk_outs("req_cycle", rdy, bsy, dn, lkd, lost, 0, prst, stpn, ld);
      chk("req_phase", 32'({phase_dir, phase_sel}), 32'({dir, sel}));
      if (hold) begin
        req_valid = 1'b1;
        req_sel   = 3'($urandom);
        req_dir   = 1'($urandom);
        req_steps = 8'($urandom);
      end else begin
        req_valid = 1'b0;
      end
      if (k == drop_k) pll_lock = 1'b0;
    end
    last_sel = sel;
    last_dir = dir;
  endtask

  // Raise pll_lock while waiting for lock; IDLE is expected three cycles later.
  task automatic relock();
    pll_lock = 1'b1;
    for (int j = 0; j <= 3; j++) begin
      if (j > 0) tick();
      chk_outs("relock", j == 3, j < 3, 0, j == 3, 0, 0, 0, 1, 0);
    end
  endtask

  // Lock loss in IDLE coinciding with a handshake, then a timed-out wait and a retry.
  task automatic timeout_seq();
    bit  prst, err, lkd;
    chk_outs("to_idle", 1, 0, 0, 1, 0, 0, 0, 1, 0);
    pll_lock = 1'b0;
    for (int j = 1; j <= 137; j++) begin
      tick();
      prst = (j >= 3 && j < 19) || (j >= 119 && j < 135);
      err  = (j >= 119 && j < 136);
      lkd  = (j < 3) || (j >= 136);
      chk_outs("timeout", lkd, !lkd, 0, lkd, j == 3, err, prst, 1, 0);
      chk("to_phase", 32'({phase_dir, phase_sel}), 32'({last_dir, last_sel}));
      if (j == 2) begin
        req_valid = 1'b1;
        req_sel   = ~last_sel;
        req_dir   = ~last_dir;
        req_steps = 8'd1;
      end
      if (j == 3) req_valid = 1'b0;
      if (j == 125) pll_lock = 1'b1;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    pll_lock  = 1'b0;
    req_valid = 1'b0;
    req_sel   = 3'd0;
    req_dir   = 1'b0;
    req_steps = 8'd0;
    tick();
    reset_seq(30);

    do_req(3'd3, 1'b1, 2, 1'b0, -1);
    do_req(3'd6, 1'b0, 0, 1'b0, -1);
    for (int r = 0; r < 6; r++) begin
      do_req(3'($urandom_range(7)), 1'($urandom_range(1)), int'($urandom_range(4)),
             r < 3, -1);
    end
    tick();
    chk_outs("idle_quiet", 1, 0, 0, 1, 0, 0, 0, 1, 0);

    do_req(3'd2, 1'b0, 5, 1'b0, 14);
    relock();
    do_req(3'($urandom_range(7)), 1'($urandom_range(1)), 1, 1'b0, -1);

    timeout_seq();

    req_valid = 1'b1;
    req_sel   = 3'd5;
    req_dir   = 1'b0;
    req_steps = 8'd3;
    tick();
    req_valid = 1'b0;
    tick();
    chk_outs("midop_low", 0, 1, 0, 1, 0, 0, 0, 0, 0);
    tick();
    reset_seq(30);
    do_req(3'($urandom_range(7)), 1'($urandom_range(1)), int'($urandom_range(1, 4)),
           1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench did not finish");
  end

endmodule
